whack_round_datapath: RTL and testbench
=======================================

// Module: whack_round_datapath
// PURPOSE
//  Parametrised whack-a-mole round engine. Runs NUM_ROUNDS timed rounds over NUM_HOLES holes.
//  Each round: mole shown, hit window arms after ARM_DELAY, player hits scored (saturating).
//  Sits between control FSM (start, mole_sel from LFSR) and score RAM / VGA mole display.
// PARAMETERS
//  NUM_HOLES     4            number of holes/buttons (>=2)
//  SCORE_W       8            score width, bits
//  ROUND_CYCLES  100_000_000  clk cycles per round (>ARM_DELAY)
//  ARM_DELAY     50_000_000   cycles from round start until hits count (>=1)
//  NUM_ROUNDS    16           rounds per game (>=1)
//  localparam SEL_W=$clog2(NUM_HOLES), CNT_W=$clog2(ROUND_CYCLES), RND_W=$clog2(NUM_ROUNDS+1)
// PORTS
//  clk          in   1          system clock
//  Reset_n      in   1          reset, asynchronous, active-low
//  start        in   1          begin new game (sampled in IDLE/DONE only)
//  mole_sel     in   SEL_W      hole for next round; latched at round start
//  hit          in   NUM_HOLES  player buttons, level, synchronous to clk
//  mole_onehot  out  NUM_HOLES  active mole for display
//  score_out    out  SCORE_W    current score
//  wren         out  1          1-cycle write strobe for score RAM (data = score_out)
//  round_done   out  1          1-cycle pulse at last cycle of each round
//  round_cnt    out  RND_W      rounds completed this game
//  game_over    out  1          high in DONE
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE; all outputs, counter, hit_prev, hit_lock = 0.
//  hit_edge = hit & ~hit_prev; hit_prev <= hit every cycle in every state.
//  mole_sel >= NUM_HOLES is latched as 0.
//  IDLE: outputs 0. start=1 -> SHOW; counter=0, round_cnt=0, score_out=0, wren=1 (clear RAM), latch mole_sel.
//  SHOW: mole_onehot=1<<mole_q; counter++; hit_edge ignored.
//    counter==ARM_DELAY-1 -> ARMED (counter keeps counting).
//  ARMED: mole shown; counter++.
//    hit_edge[mole_q] & ~hit_lock -> score_out=sat(score_out+1) (max 2^SCORE_W-1 holds), wren=1 next cycle, hit_lock=1.
//    counter==ROUND_CYCLES-1: round_done=1, round_cnt++, counter=0, hit_lock=0;
//      round_cnt==NUM_ROUNDS-1 -> DONE, else -> SHOW with new mole_sel latched.
//    Hit edge on the final window cycle still scores (evaluated before round end).
//  DONE: game_over=1, mole_onehot=0, score_out held. start=1 -> same as IDLE start (game_over drops).
//  wren and round_done are single-cycle pulses, registered (1 cycle after cause).
//  Held button across SHOW->ARMED never scores (edge only). Multiple edges on correct hole: one point/round.
//  Reset mid-round: immediate return to IDLE, score lost, no wren.
// CONFIGURATION
//  MISS_PENALTY_EN defined: in ARMED, any hit_edge on a hole != mole_q with ~hit_lock
//    -> score_out=score_out-1 saturating at 0, wren pulse; each wrong edge penalised;
//    same-cycle correct+wrong edges: correct wins (score +1 only, hit_lock=1).
//  Not defined: wrong-hole edges ignored; no decrement logic synthesised.
// TESTING (NUM_HOLES=4, SCORE_W=3, ROUND_CYCLES=10, ARM_DELAY=4, NUM_ROUNDS=3)
//  1 Reset_n low mid-ARMED -> all outputs 0 async; after release stays IDLE until start.
//  2 start, mole_sel=2, hit[2] rising at counter=6 -> score_out=1, one wren pulse, mole_onehot=4'b0100.
//  3 hit[2] rising at counter=2 (SHOW) and held -> no score; rising again in ARMED -> +1.
//  4 Three correct hits per round for 3 rounds -> score 3 (one per round), round_done x3, round_cnt=3, game_over=1.
//  5 Score at 7, correct hit -> stays 7, wren still pulses; mole_sel=5 -> hole 0 used.
//  6 MISS_PENALTY_EN: score 0, hit[1] with mole 3 -> stays 0; score 2, wrong+correct same cycle -> 3.

Source files
------------

// File: rtl/whack_round_datapath_if.sv
// Bundles the round engine's control inputs and display/score outputs.
// master: control side (drives start, mole_sel, hit)
// slave: round engine (drives mole_onehot, score and status)
interface whack_round_datapath_if #(
  parameter int NUM_HOLES  = 4,
  parameter int SCORE_W    = 8,
  parameter int NUM_ROUNDS = 16
);
  localparam int SEL_W = $clog2(NUM_HOLES);
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);

  logic                 start;
  logic [SEL_W-1:0]     mole_sel;
  logic [NUM_HOLES-1:0] hit;
  logic [NUM_HOLES-1:0] mole_onehot;
  logic [SCORE_W-1:0]   score_out;
  logic                 wren;
  logic                 round_done;
  logic [RND_W-1:0]     round_cnt;
  logic                 game_over;

  modport master (
    output start, mole_sel, hit,
    input  mole_onehot, score_out, wren, round_done, round_cnt, game_over
  );

  modport slave (
    input  start, mole_sel, hit,
    output mole_onehot, score_out, wren, round_done, round_cnt, game_over
  );
endinterface

// File: rtl/whack_round_datapath.sv
// Whack-a-mole round engine: runs NUM_ROUNDS timed rounds. Each round shows a
// mole, opens a hit window ARM_DELAY cycles in, and scores at most one correct
// hit (rising edge on the mole's hole) with a saturating score.
// Optional build macro MISS_PENALTY_EN: wrong-hole edges inside an unlocked
// window decrement the score (saturating at 0) and pulse wren.
module whack_round_datapath #(
  parameter int NUM_HOLES    = 4,
  parameter int SCORE_W      = 8,
  parameter int ROUND_CYCLES = 100_000_000,
  parameter int ARM_DELAY    = 50_000_000,
  parameter int NUM_ROUNDS   = 16
) (
  input  logic clk,
  input  logic Reset_n,
  whack_round_datapath_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_HOLES);
  localparam int CNT_W = $clog2(ROUND_CYCLES);
  localparam int RND_W = $clog2(NUM_ROUNDS + 1);

  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [RND_W-1:0] FINAL_RND  = RND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ARMED, DONE} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     counter_reg, counter_next;
  logic [SEL_W-1:0]     mole_reg, mole_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic                 wren_reg, wren_next;
  logic                 round_done_reg, round_done_next;
  logic [RND_W-1:0]     round_cnt_reg, round_cnt_next;
  logic [NUM_HOLES-1:0] hit_prev_reg;
  logic                 hit_lock_reg, hit_lock_next;

  logic [NUM_HOLES-1:0] hit_edge;
  logic [NUM_HOLES-1:0] mole_mask;
  logic [SEL_W-1:0]     sel_clamped;
  logic [SCORE_W-1:0]   score_inc;
  logic                 correct_hit;

  // Per-hole rising-edge detect and one-hot decode of the latched mole.
  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
    assign hit_edge[gi]  = bus.hit[gi] & ~hit_prev_reg[gi];
    assign mole_mask[gi] = (mole_reg == SEL_W'(gi));
  end

  assign correct_hit = (|(hit_edge & mole_mask)) & ~hit_lock_reg;
  assign score_inc   = (score_reg == {SCORE_W{1'b1}}) ? score_reg : score_reg + 1'b1;

`ifdef MISS_PENALTY_EN
  logic                 wrong_hit;
  logic [SCORE_W-1:0]   score_dec;
  assign wrong_hit = (|(hit_edge & ~mole_mask)) & ~hit_lock_reg;
  assign score_dec = (score_reg == '0) ? score_reg : score_reg - 1'b1;
`endif

  // Out-of-range hole selections fall back to hole 0.
  always_comb begin
    sel_clamped = bus.mole_sel;
    if (int'(bus.mole_sel) >= NUM_HOLES) sel_clamped = '0;
  end

  // Next-state and datapath updates; pulses default low every cycle.
  always_comb begin
    state_next      = state_reg;
    counter_next    = counter_reg;
    mole_next       = mole_reg;
    score_next      = score_reg;
    wren_next       = 1'b0;
    round_done_next = 1'b0;
    round_cnt_next  = round_cnt_reg;
    hit_lock_next   = hit_lock_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next     = SHOW;
          counter_next   = '0;
          round_cnt_next = '0;
          score_next     = '0;
          wren_next      = 1'b1;  // clears the stored score
          mole_next      = sel_clamped;
          hit_lock_next  = 1'b0;
        end
      end

      SHOW: begin
        counter_next = counter_reg + 1'b1;
        if (counter_reg == ARM_LAST) state_next = ARMED;
      end

      ARMED: begin
        counter_next = counter_reg + 1'b1;
        // Hit scoring is evaluated before the round-end handling below, so
        // an edge on the last window cycle still counts.
        if (correct_hit) begin
          score_next    = score_inc;
          wren_next     = 1'b1;
          hit_lock_next = 1'b1;
        end
`ifdef MISS_PENALTY_EN
        else if (wrong_hit) begin
          score_next = score_dec;
          wren_next  = 1'b1;
        end
`endif
        if (counter_reg == ROUND_LAST) begin
          counter_next    = '0;
          round_done_next = 1'b1;
          round_cnt_next  = round_cnt_reg + 1'b1;
          hit_lock_next   = 1'b0;
          if (round_cnt_reg == FINAL_RND) begin
            state_next = DONE;
          end else begin
            state_next = SHOW;
            mole_next  = sel_clamped;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any round in progress.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      mole_reg       <= '0;
      score_reg      <= '0;
      wren_reg       <= 1'b0;
      round_done_reg <= 1'b0;
      round_cnt_reg  <= '0;
      hit_prev_reg   <= '0;
      hit_lock_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      mole_reg       <= mole_next;
      score_reg      <= score_next;
      wren_reg       <= wren_next;
      round_done_reg <= round_done_next;
      round_cnt_reg  <= round_cnt_next;
      hit_prev_reg   <= bus.hit;
      hit_lock_reg   <= hit_lock_next;
    end
  end

  assign bus.mole_onehot = (state_reg == SHOW || state_reg == ARMED) ? mole_mask : '0;
  assign bus.score_out   = score_reg;
  assign bus.wren        = wren_reg;
  assign bus.round_done  = round_done_reg;
  assign bus.round_cnt   = round_cnt_reg;
  assign bus.game_over   = (state_reg == DONE);
endmodule

// File: tb/tb_whack_round_datapath.sv
// Scoreboard bench for whack_round_datapath. Main instance uses the small test
// configuration; a second instance (5 holes, 9 rounds) covers score saturation
// and out-of-range mole selection.
module tb_whack_round_datapath;
  localparam int RC = 10;

  logic clk;
  logic Reset_n;

  whack_round_datapath_if #(.NUM_HOLES(4), .SCORE_W(3), .NUM_ROUNDS(3)) bus ();
  whack_round_datapath_if #(.NUM_HOLES(5), .SCORE_W(3), .NUM_ROUNDS(9)) bus2 ();

  whack_round_datapath #(
    .NUM_HOLES(4), .SCORE_W(3), .ROUND_CYCLES(RC), .ARM_DELAY(4), .NUM_ROUNDS(3)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .bus(bus)
  );

  whack_round_datapath #(
    .NUM_HOLES(5), .SCORE_W(3), .ROUND_CYCLES(4), .ARM_DELAY(1), .NUM_ROUNDS(9)
  ) dut2 (
    .clk(clk), .Reset_n(Reset_n), .bus(bus2)
  );

  typedef struct {
    int rc;
    int go;
    int sc;
  } rd_t;

  int  wren_q[$];
  int  wren2_q[$];
  rd_t rd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int period = RC;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the main instance: every wren / round_done pulse pops one expectation.
  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      if (wren_q.size() == 0) begin
        check("wren_unexpected", 1, 0);
      end else begin
        int e;
        e = wren_q.pop_front();
        $display("wren   score=%0d exp=%0d", bus.score_out, e);
        check("wren_score", int'(bus.score_out), e);
      end
    end
    if (bus.round_done === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("round_done_unexpected", 1, 0);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        $display("round  cnt=%0d game_over=%0d score=%0d", bus.round_cnt, bus.game_over, bus.score_out);
        check("round_cnt", int'(bus.round_cnt), r.rc);
        check("round_game_over", int'(bus.game_over), r.go);
        check("round_score", int'(bus.score_out), r.sc);
      end
    end
  end

  // Monitor for the saturation instance (wren only).
  always @(negedge clk) begin
    if (bus2.wren === 1'b1) begin
      if (wren2_q.size() == 0) begin
        check("wren2_unexpected", 1, 0);
      end else begin
        int e;
        e = wren2_q.pop_front();
        $display("wren2  score=%0d exp=%0d", bus2.score_out, e);
        check("wren2_score", int'(bus2.score_out), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = (cyc + 1) % period;
  endtask

  task automatic goto_cyc(input int c);
    for (int k = 0; k < period && cyc != c; k++) tick();
  endtask

  task automatic start_game(input int sel);
    bus.start    = 1'b1;
    bus.mole_sel = 2'(sel);
    wren_q.push_back(0);
    tick();
    bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse(input int c, input logic [3:0] mask);
    goto_cyc(c);
    bus.hit = mask;
    tick();
    bus.hit = '0;
  endtask

  task automatic finish_round(input int rc, input int go, input int sc);
    rd_t r;
    goto_cyc(period - 1);
    r.rc = rc; r.go = go; r.sc = sc;
    rd_q.push_back(r);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mole"}, int'(bus.mole_onehot), 0);
    check({tag, "_score"}, int'(bus.score_out), 0);
    check({tag, "_wren"}, int'(bus.wren), 0);
    check({tag, "_round_done"}, int'(bus.round_done), 0);
    check({tag, "_round_cnt"}, int'(bus.round_cnt), 0);
    check({tag, "_game_over"}, int'(bus.game_over), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sat_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 7};
    Reset_n = 1'b1;
    bus.start = 1'b0; bus.mole_sel = '0; bus.hit = '0;
    bus2.start = 1'b0; bus2.mole_sel = '0; bus2.hit = '0;

    // Power-on reset
    #3 Reset_n = 1'b0;
    #1 check_outputs_zero("por");
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    tick();

    // Reset mid-ARMED: outputs clear asynchronously, no wren, stays IDLE
    start_game(1);
    goto_cyc(6);
    #2 Reset_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    repeat (3) tick();
    check_outputs_zero("idle_after_rst");

    // Game A: scoring hit at counter 6, then held-button across arming
    start_game(2);
    check("show_mole", int'(bus.mole_onehot), 4'b0100);
    wren_q.push_back(1);
    pulse(6, 4'b0100);
    finish_round(1, 0, 1);
    goto_cyc(2);
    bus.hit = 4'b0100;          // rises in SHOW, held into ARMED
    goto_cyc(6);
    bus.hit = '0;
    wren_q.push_back(2);
    pulse(7, 4'b0100);
    finish_round(2, 0, 2);
    finish_round(3, 1, 2);
    check("done_game_over", int'(bus.game_over), 1);
    check("done_mole", int'(bus.mole_onehot), 0);
    check("done_round_cnt", int'(bus.round_cnt), 3);
    repeat (2) tick();
    check("done_score_held", int'(bus.score_out), 2);

    // Game B: three hits per round score once; last-cycle hit scores
    start_game(1);
    check("restart_game_over", int'(bus.game_over), 0);
    check("restart_round_cnt", int'(bus.round_cnt), 0);
    wren_q.push_back(1);
    pulse(4, 4'b0010); pulse(6, 4'b0010); pulse(8, 4'b0010);
    finish_round(1, 0, 1);
    wren_q.push_back(2);
    pulse(4, 4'b0010); pulse(6, 4'b0010);
    bus.mole_sel = 2'd3;
    pulse(8, 4'b0010);
    finish_round(2, 0, 2);
    check("new_mole", int'(bus.mole_onehot), 4'b1000);
    goto_cyc(9);
    bus.hit = 4'b1000;
    wren_q.push_back(3);
    finish_round(3, 1, 3);
    bus.hit = '0;
    check("b_game_over", int'(bus.game_over), 1);

    // Game D: wrong-hole edges (penalised only with MISS_PENALTY_EN)
    start_game(3);
`ifdef MISS_PENALTY_EN
    wren_q.push_back(0);
`endif
    pulse(5, 4'b0010);
    wren_q.push_back(1);
    pulse(7, 4'b1000);
    finish_round(1, 0, 1);
    wren_q.push_back(2);
    pulse(5, 4'b1000);
    pulse(7, 4'b0001);          // locked for this round
    finish_round(2, 0, 2);
    wren_q.push_back(3);
    pulse(5, 4'b1010);          // correct and wrong together
    finish_round(3, 1, 3);

    // Second instance: out-of-range mole_sel and score saturation at 7
    period = 4;
    bus2.start = 1'b1;
    bus2.mole_sel = 3'd5;
    wren2_q.push_back(0);
    tick();
    bus2.start = 1'b0;
    cyc = 0;
    check("clamp_mole", int'(bus2.mole_onehot), 5'b00001);
    for (int r = 0; r < 8; r++) begin
      goto_cyc(1);
      bus2.hit = 5'b00001;
      wren2_q.push_back(sat_exp[r]);
      tick();
      bus2.hit = '0;
      goto_cyc(0);
    end
    check("sat_score", int'(bus2.score_out), 7);

    repeat (3) tick();
    check("wren_q_empty", wren_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("wren2_q_empty", wren2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
